// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 MSB-first SPI slave with rx/tx valid/ready handshakes
// Optional feature: SPI_SLAVE_OVERRUN_DETECT_EN (drop words and flag overrun when rx is not drained)
module spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t                state;
    logic [2:0]            sclk_q;
    logic [2:0]            ss_q;
    logic [1:0]            mosi_q;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  rx_done;

    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
    logic tx_take;
    logic [DATA_WIDTH-1:0] tx_next;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];

    // The holding buffer is empty exactly when tx_ready is high.
    assign tx_next = tx_ready ? TX_IDLE : tx_buf;
    assign miso    = miso_oe & tx_shift[DATA_WIDTH-1];

    always_comb begin
        tx_take = 1'b0;
        if (state == ST_IDLE)
            tx_take = ss_fall;
        else
            tx_take = !ss_rise && sclk_fall && (bit_cnt == '0);
    end

`ifndef SPI_SLAVE_OVERRUN_DETECT_EN
    assign rx_overrun = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sclk_q   <= '0;
            ss_q     <= '0;
            mosi_q   <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            tx_buf   <= '0;
            tx_ready <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_done  <= 1'b0;
            miso_oe  <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_DETECT_EN
            rx_overrun <= 1'b0;
`endif
        end else begin
            // Synchronizer history starts low so a frame already in progress at reset is ignored.
            sclk_q  <= {sclk_q[1:0], sclk};
            ss_q    <= {ss_q[1:0], ss_n};
            mosi_q  <= {mosi_q[0], mosi};
            rx_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    miso_oe <= 1'b0;
                    if (ss_fall) begin
                        state    <= ST_SHIFT;
                        miso_oe  <= 1'b1;
                        tx_shift <= tx_next;
                    end
                end
                ST_SHIFT: begin
                    if (ss_rise) begin
                        state    <= ST_IDLE;
                        miso_oe  <= 1'b0;
                        rx_shift <= '0;
                        bit_cnt  <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_q[1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                rx_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (bit_cnt == '0)
                                tx_shift <= tx_next;
                            else
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A load in the same cycle as a take from an empty buffer lands after TX_IDLE was used.
            if (tx_take && !tx_ready)
                tx_ready <= 1'b1;
            if (tx_valid && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end

            if (rx_done) begin
`ifdef SPI_SLAVE_OVERRUN_DETECT_EN
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
`else
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
`endif
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave, SCLK = clk/8, TX_IDLE = 0xFF
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;

    int errors = 0;
    int checks = 0;
    logic [7:0] rxq[$];
    logic [7:0] r0, r1, r2;

    spi_slave #(.DATA_WIDTH(8), .TX_IDLE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    // Record each accepted rx word, sampled after the negedge input updates.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && rx_valid && rx_ready)
            rxq.push_back(rx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        if (rxq.size() > 0)
            check(tag, {24'd0, rxq.pop_front()}, {24'd0, exp});
        else
            check({tag, "_missing"}, 32'hFFFF_FFFF, {24'd0, exp});
    endtask

    task automatic spi_bits(input logic [7:0] w, input int nbits, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[7-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            r[7-i] = miso;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] w, output logic [7:0] r);
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(w, 8, r);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic tx_load(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic tx_feed(input logic [7:0] w);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready)
            check("tx_feed_timeout", 32'd0, 32'd1);
        else
            tx_load(w);
    endtask

    initial begin
        logic [7:0] r;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_overrun", rx_overrun, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame with a preloaded transmit word
        tx_load(8'hA5);
        check("t1_tx_ready_low", tx_ready, 0);
        spi_frame(8'h3C, r);
        check("t1_miso_word", r, 8'hA5);
        check("t1_rx_valid", rx_valid, 1);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_tx_ready_back", tx_ready, 1);
        check("t1_miso_oe_idle", miso_oe, 0);
        repeat (10) @(negedge clk);
        check("t1_rx_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_rx_valid_clr", rx_valid, 0);
        pop_rx("t1_rxq", 8'h3C);

        // Three back-to-back words in one select
        tx_load(8'h11);
        fork
            begin
                ss_n = 1'b0;
                repeat (4) @(negedge clk);
                spi_bits(8'hC1, 8, r0);
                spi_bits(8'hC2, 8, r1);
                spi_bits(8'hC3, 8, r2);
                repeat (4) @(negedge clk);
                ss_n = 1'b1;
                repeat (6) @(negedge clk);
            end
            begin
                tx_feed(8'h22);
                tx_feed(8'h33);
            end
        join
        check("t2_miso0", r0, 8'h11);
        check("t2_miso1", r1, 8'h22);
        check("t2_miso2", r2, 8'h33);
        check("t2_rx_count", rxq.size(), 3);
        pop_rx("t2_rx0", 8'hC1);
        pop_rx("t2_rx1", 8'hC2);
        pop_rx("t2_rx2", 8'hC3);

        // Empty transmit buffer shifts TX_IDLE
        spi_frame(8'h5A, r);
        check("t3_miso_idle", r, 8'hFF);
        check("t3_rx_data", rx_data, 8'h5A);
        pop_rx("t3_rxq", 8'h5A);

        // Aborted frame after five bits, then a full word
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits(8'hF0, 5, r);
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_no_rx_valid", rx_valid, 0);
        check("t4_no_rx_word", rxq.size(), 0);
        spi_frame(8'h81, r);
        check("t4_rx_data", rx_data, 8'h81);
        check("t4_miso_idle", r, 8'hFF);
        pop_rx("t4_rxq", 8'h81);

        // Two words with rx_ready held low
        rx_ready = 1'b0;
        spi_frame(8'h01, r);
        spi_frame(8'h02, r);
        check("t5_rx_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_DETECT_EN
        check("t5_rx_data", rx_data, 8'h01);
        check("t5_overrun", rx_overrun, 1);
`else
        check("t5_rx_data", rx_data, 8'h02);
        check("t5_overrun", rx_overrun, 0);
`endif
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rxq.delete();

        // Reset in the middle of a frame
        tx_load(8'hC3);
        ss_n = 1'b0;
        repeat (4) @(negedge clk);
        tx_load(8'h99);
        spi_bits(8'hE0, 3, r);
        check("t6_pre_miso_oe", miso_oe, 1);
        check("t6_pre_tx_ready", tx_ready, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_miso", miso, 0);
        check("t6_rst_miso_oe", miso_oe, 0);
        check("t6_rst_tx_ready", tx_ready, 1);
        check("t6_rst_rx_valid", rx_valid, 0);
        check("t6_rst_rx_data", rx_data, 0);
        check("t6_rst_overrun", rx_overrun, 0);
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_frame(8'h7E, r);
        check("t6_rx_data", rx_data, 8'h7E);
        check("t6_miso_idle", r, 8'hFF);
        pop_rx("t6_rxq", 8'h7E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
